// File: rtl/state_trace_pkg.sv
// Shared definitions for the state trace monitor: state codes, the legal
// transition set and the bit layout of a trace event.
package state_trace_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;
    localparam logic [1:0] S3 = 2'b11;

    // Event layout, MSB first: {old_state, new_state, dwell}
    localparam int DWELL_LSB = 0;

    function automatic int new_state_lsb(input int cnt_w);
        return cnt_w;
    endfunction

    function automatic int old_state_lsb(input int cnt_w);
        return cnt_w + 2;
    endfunction

    function automatic logic is_legal(input logic [1:0] from_s, input logic [1:0] to_s);
        logic ok;
        case ({from_s, to_s})
            {S0, S1},
            {S1, S2},
            {S1, S3},
            {S2, S3},
            {S3, S0}: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO. The head entry is presented whenever the FIFO
// is non-empty; a push while full is accepted only if a pop frees a slot on
// the same edge.
module event_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     level
);
    import state_trace_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             is_full;
    logic             do_pop;
    logic             do_push;

    assign head_valid = (level != '0);
    assign is_full    = (level == LVL_W'(DEPTH));
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (!is_full || do_pop);
    // Gate the head so the output reads zero while empty or in reset.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/state_trace_monitor.sv
// Watches the state code of an upstream Moore FSM, measures how many enabled
// samples each state lasted, and queues one event per state change. Sticky
// flags record dropped events and transitions outside the legal set.
module state_trace_monitor #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 state_in,
    input  logic                       enable,
    input  logic                       rd_ready,
    input  logic                       clr_flags,
    output logic                       rd_valid,
    output logic [4+CNT_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       illegal
);
    import state_trace_pkg::*;

    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int EV_W    = 4 + CNT_W;
    localparam int OLD_LSB = old_state_lsb(CNT_W);
    localparam int NEW_LSB = new_state_lsb(CNT_W);
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    logic [1:0]       last_state;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] dwell_inc;
    logic             ev_push;
    logic [EV_W-1:0]  ev_data;
    logic             fifo_full;
    logic             pop;
    logic             ovf_set;
    logic             ill_set;

    assign dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);
    assign ev_push   = enable && (state_in != last_state);
    assign pop       = rd_valid && rd_ready;
    assign fifo_full = (level == LVL_W'(DEPTH));
    assign ovf_set   = ev_push && fifo_full && !pop;
    assign ill_set   = ev_push && !is_legal(last_state, state_in);

    // Pack the outgoing event; the dwell includes the sample that ended the state.
    always_comb begin
        ev_data = '0;
        ev_data[OLD_LSB +: 2]       = last_state;
        ev_data[NEW_LSB +: 2]       = state_in;
        ev_data[DWELL_LSB +: CNT_W] = dwell_inc;
    end

    // Edge detect and dwell counter, frozen while enable is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_state <= S0;
            dwell      <= '0;
        end else if (enable) begin
            if (state_in == last_state) begin
                dwell <= dwell_inc;
            end else begin
                last_state <= state_in;
                dwell      <= CNT_W'(1);
            end
        end
    end

    // Sticky flags; a new set condition beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (ill_set) begin
                illegal <= 1'b1;
            end else if (clr_flags) begin
                illegal <= 1'b0;
            end
        end
    end

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_event_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (ev_push),
        .push_data  (ev_data),
        .pop        (pop),
        .head_valid (rd_valid),
        .head_data  (rd_data),
        .level      (level)
    );

endmodule

// File: tb/tb_state_trace_monitor.sv
// Directed bench for state_trace_monitor with DEPTH=8, CNT_W=8.
module tb_state_trace_monitor;

    logic        clock;
    logic        reset;
    logic [1:0]  state_in;
    logic        enable;
    logic        rd_ready;
    logic        clr_flags;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [3:0]  level;
    logic        overflow;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    state_trace_monitor #(
        .DEPTH (8),
        .CNT_W (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .state_in  (state_in),
        .enable    (enable),
        .rd_ready  (rd_ready),
        .clr_flags (clr_flags),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .level     (level),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        rd_ready  = 1'b0;
        clr_flags = 1'b0;
        state_in  = 2'b00;
        step();
        reset = 1'b1;
    endtask

    logic [1:0]  seq9  [9] = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
    logic [11:0] exp8  [8] = '{12'h101, 12'h702, 12'hC02, 12'h102, 12'h702, 12'hC02, 12'h102, 12'h702};

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        rd_ready  = 1'b0;
        clr_flags = 1'b0;
        state_in  = 2'b00;
        step();
        step();
        check_val("rst_valid",    rd_valid, 0);
        check_val("rst_level",    level,    0);
        check_val("rst_overflow", overflow, 0);
        check_val("rst_illegal",  illegal,  0);
        check_val("rst_data",     rd_data,  0);
        reset = 1'b1;

        // basic event: 00,00,01
        enable   = 1'b1;
        state_in = 2'b00; step();
        state_in = 2'b00; step();
        check_val("basic_no_ev", rd_valid, 0);
        state_in = 2'b01; step();
        check_val("basic_valid",   rd_valid, 1);
        check_val("basic_data",    rd_data,  12'h103);
        check_val("basic_level",   level,    1);
        check_val("basic_illegal", illegal,  0);

        // overflow: 9 events into an 8-deep FIFO
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            state_in = seq9[i];
            step();
        end
        enable = 1'b0;
        check_val("ovf_level",    level,    8);
        check_val("ovf_flag",     overflow, 1);
        check_val("ovf_illegal",  illegal,  0);
        step();
        check_val("ovf_hold_data", rd_data, 12'h101);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("ovf_rd%0d", i), rd_data, exp8[i]);
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        check_val("ovf_empty_valid", rd_valid, 0);
        check_val("ovf_empty_level", level,    0);
        clr_flags = 1'b1; step(); clr_flags = 1'b0;
        check_val("ovf_cleared", overflow, 0);

        // dwell saturation
        apply_reset();
        enable   = 1'b1;
        rd_ready = 1'b1;
        state_in = 2'b01; step();
        state_in = 2'b10; step();
        repeat (300) step();
        state_in = 2'b11; step();
        check_val("sat_valid",   rd_valid, 1);
        check_val("sat_data",    rd_data,  12'hBFF);
        check_val("sat_illegal", illegal,  0);

        // illegal transitions and clear priority
        apply_reset();
        enable   = 1'b1;
        rd_ready = 1'b1;
        state_in = 2'b10; step();
        check_val("ill_flag",  illegal, 1);
        check_val("ill_data",  rd_data, 12'h201);
        check_val("ill_valid", rd_valid, 1);
        enable    = 1'b0;
        clr_flags = 1'b1; step();
        check_val("ill_clr", illegal, 0);
        enable   = 1'b1;
        state_in = 2'b00; step();
        clr_flags = 1'b0;
        check_val("ill_set_wins", illegal, 1);
        check_val("ill_data2",    rd_data, 12'h802);

        // full FIFO with simultaneous pop and push
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            state_in = seq9[i];
            step();
        end
        check_val("fpp_full", level, 8);
        state_in = 2'b00;
        rd_ready = 1'b1;
        step();
        enable = 1'b0;
        check_val("fpp_level",    level,    8);
        check_val("fpp_overflow", overflow, 0);
        check_val("fpp_head",     rd_data,  12'h702);
        repeat (7) step();
        check_val("fpp_last_level", level,   1);
        check_val("fpp_last_data",  rd_data, 12'hC02);
        step();
        rd_ready = 1'b0;

        // mid-operation reset discards queue and dwell
        apply_reset();
        enable   = 1'b1;
        state_in = 2'b01; step();
        state_in = 2'b11; step();
        state_in = 2'b00; step();
        repeat (4) step();
        check_val("mrst_pre_level", level, 3);
        reset = 1'b0;
        #1;
        check_val("mrst_level", level,    0);
        check_val("mrst_valid", rd_valid, 0);
        check_val("mrst_data",  rd_data,  0);
        step();
        reset    = 1'b1;
        state_in = 2'b00; step();
        state_in = 2'b00; step();
        check_val("mrst_no_ev", level, 0);
        state_in = 2'b01; step();
        check_val("mrst_post_level", level,   1);
        check_val("mrst_post_data",  rd_data, 12'h103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/state_trace_monitor.md
STATE_TRACE_MONITOR -- requirements
Module: state_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, dwell counter width.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port state_in  input  2  state code from the upstream Moore FSM (S0=00, S1=01, S2=10, S3=11).
REQ-006 SHALL have port enable  input  1  sample state_in on this edge.
REQ-007 SHALL have port rd_ready  input  1  consumer accepts head event.
REQ-008 SHALL have port clr_flags  input  1  clear the sticky flags.
REQ-009 SHALL have port rd_valid  output  1  head event available.
REQ-010 SHALL have port rd_data  output  4+CNT_W  {old_state[1:0], new_state[1:0], dwell[CNT_W-1:0]}, MSB first.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky: an event was dropped.
REQ-013 SHALL have port illegal  output  1  sticky: a transition not in the legal set was seen.

Function
REQ-014 SHALL hold last_state and dwell registers; last_state=00 and dwell=0 after reset.
REQ-015 SHALL, on an edge with enable=1 and state_in==last_state, set dwell to dwell+1, saturating at 2^CNT_W-1.
REQ-016 SHALL, on an edge with enable=1 and state_in!=last_state, generate the event {last_state, state_in, sat(dwell+1)}, then load last_state=state_in and dwell=1.
REQ-017 SHALL, with enable=0, leave last_state and dwell frozen and generate no event; reads still proceed.
REQ-018 SHALL treat the legal set as {00->01, 01->10, 01->11, 10->11, 11->00}; any other generated event SHALL set illegal on that edge and still be queued.
REQ-019 SHALL push each generated event into the FIFO; it is visible on rd_valid/rd_data one edge later, with latency 1 when the FIFO was empty.
REQ-020 SHALL drive rd_valid=1 exactly when level>0 and SHALL present the oldest entry on rd_data (show-ahead).
REQ-021 SHALL pop on an edge with rd_valid=1 and rd_ready=1; rd_data SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-022 SHALL, when full with a simultaneous pop and push, accept both; level stays DEPTH.
REQ-023 SHALL, when full with a push and no pop, drop the new event, leave FIFO contents unchanged and set overflow.
REQ-024 SHALL, on a push into an empty FIFO with rd_ready=1, not pop that event in the same edge.
REQ-025 SHALL clear overflow and illegal on clr_flags=1, except that a set condition on the same edge wins.
REQ-026 SHALL wrap read and write pointers modulo DEPTH and derive full/empty from level.

Reset
REQ-027 SHALL, while reset=0, force rd_valid=0, level=0, overflow=0, illegal=0, rd_data=0, last_state=00, dwell=0, and both pointers to 0.
REQ-028 SHALL discard all queued events on a reset asserted mid-operation, with no partial event emitted after release.
REQ-029 SHALL sample normally from the first rising edge after reset deasserts.

Structure
REQ-030 SHALL place state encodings S0..S3, the legal-transition check function, and rd_data field offsets in a shared package state_trace_pkg.
REQ-031 SHALL instantiate one sub-module event_fifo (synchronous, show-ahead, parameterised width/depth) for the queue; the edge detect, dwell and flag logic SHALL stay in the top module.

Verification
REQ-032 SHALL cover: reset, enable=1, state_in 00,00,01 -> rd_valid one edge after the 01 sample, rd_data={00,01,dwell=3}, illegal=0.
REQ-033 SHALL cover: rd_ready=0, 9 alternating transitions 00->01->11->00... with DEPTH=8 -> level=8, overflow=1, the first 8 events are read back in order, and the 9th is absent.
REQ-034 SHALL cover: state_in held at 10 for 300 cycles, then 11 -> event {10,11,255} (saturated) with CNT_W=8.
REQ-035 SHALL cover: 00->10 transition -> illegal=1, event queued; clr_flags pulse -> illegal=0; clr_flags coincident with a new illegal event -> illegal stays 1.
REQ-036 SHALL cover: full FIFO with rd_ready=1 and a transition on the same edge -> both complete, level=8, overflow=0.
REQ-037 SHALL cover: reset pulse with 3 queued events and dwell=5 -> level=0, rd_valid=0, and the next transition reports dwell counted from reset.
